serial_adder: RTL and testbench

- Bit-serial, LSB-first adder that sequences WIDTH-bit operands through a one-bit full-adder cell, one bit per clock.
- The cell is two half_adder instances plus an OR gate on their carries.
- A registered carry links successive bits.
- Sits in the arithmetic datapath wherever area matters more than latency; a controller issues a start and collects the result on done.

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell (two half adders),
// a registered carry, and IDLE/RUN/DONE sequencing with a one-cycle done pulse.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               p_w, g0_w, g1_w, bit_w, carry_nx;
    logic [WIDTH-1:0]   shifted;

    half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(p_w),   .c_o(g0_w));
    half_adder u_ha1 (.a_i(p_w),    .b_i(carry_q), .s_o(bit_w), .c_o(g1_w));

    assign carry_nx = g0_w | g1_w;
    // Full result as it stands after this cycle's bit enters at the MSB
    assign shifted  = {bit_w, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = shifted[WIDTH-1:1];
                carry_d = carry_nx;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = shifted;
                    cout_d  = carry_nx;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=2.
// Expected {cout,sum} = a+b+cin is queued at issue; a monitor pops on done.
module tb_serial_adder;
    logic clk = 0;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q8[$];
    int q2[$];
    int dcyc8[$];
    int dcnt8 = 0;
    int prev8 = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a DUT presents done
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            dcnt8++;
            dcyc8.push_back(cyc);
            if (q8.size() == 0) chk("dut8 unexpected done", done8, 0);
            else chk("dut8 result", {cout8, sum8}, q8.pop_front());
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) chk("dut2 unexpected done", done2, 0);
            else chk("dut2 result", {cout2, sum2}, q2.pop_front());
        end
    end

    // Directed WIDTH=8 op with cycle-accurate busy/done/hold checks;
    // optionally pulses a spurious start during RUN cycle 3.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input bit spurious);
        int e;
        @(negedge clk);
        start8 = 1; a8 = ia; b8 = ib; cin8 = ic;
        e = int'(ia) + int'(ib) + int'(ic);
        q8.push_back(e);
        @(negedge clk);
        start8 = 0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            chk("run busy", busy8, 1);
            chk("run done low", done8, 0);
            chk("run sum hold", {cout8, sum8}, prev8);
            if (spurious && i == 2) begin
                start8 = 1; a8 = 8'h11; b8 = 8'h22;
            end
            if (spurious && i == 3) start8 = 0;
            @(negedge clk);
        end
        chk("done pulse", done8, 1);
        chk("done busy low", busy8, 0);
        prev8 = e;
        @(negedge clk);
        chk("done one cycle", done8, 0);
    endtask

    initial begin
        int d0;
        rst_n = 0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        #1;
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset sum", {cout8, sum8}, 0);
        chk("reset dut2", {busy2, done2, cout2, sum2}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        run8(8'h3C, 8'h5A, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hFF, 8'hFF, 1'b1, 0);
        run8(8'h00, 8'h00, 1'b1, 0);
        run8(8'h12, 8'h34, 1'b0, 1);

        // Asynchronous reset in the middle of RUN cycle 4
        @(negedge clk);
        start8 = 1; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1;
        q8.push_back(8'hA5 + 8'h5A + 1);
        @(posedge clk);
        #1 start8 = 0;
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("abort busy", busy8, 0);
        chk("abort done", done8, 0);
        chk("abort sum", sum8, 0);
        chk("abort cout", cout8, 0);
        q8.delete();
        prev8 = 0;
        #10 rst_n = 1;
        d0 = dcnt8;
        repeat (20) @(negedge clk);
        chk("no done after abort", dcnt8 - d0, 0);

        // start held high, operands changing every cycle
        dcyc8.delete();
        for (int k = 0; k < 50; k++) begin
            start8 = 1;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            if (k % 10 == 0) q8.push_back(int'(a8) + int'(b8) + int'(cin8));
            @(negedge clk);
        end
        start8 = 0;
        repeat (12) @(negedge clk);
        chk("held done count", dcyc8.size(), 5);
        for (int i = 1; i < dcyc8.size(); i++)
            chk("held done spacing", dcyc8[i] - dcyc8[i-1], 10);

        fork
            for (int n = 0; n < 1000; n++) begin
                start8 = 1;
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                cin8 = 1'($urandom_range(0, 1));
                q8.push_back(int'(a8) + int'(b8) + int'(cin8));
                @(negedge clk);
                start8 = 0;
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                cin8 = 1'($urandom_range(0, 1));
                repeat (9 + $urandom_range(0, 2)) @(negedge clk);
            end
            for (int n = 0; n < 1000; n++) begin
                start2 = 1;
                a2 = 2'($urandom_range(0, 3));
                b2 = 2'($urandom_range(0, 3));
                cin2 = 1'($urandom_range(0, 1));
                q2.push_back(int'(a2) + int'(b2) + int'(cin2));
                @(negedge clk);
                start2 = 0;
                a2 = 2'($urandom_range(0, 3));
                b2 = 2'($urandom_range(0, 3));
                cin2 = 1'($urandom_range(0, 1));
                repeat (3 + $urandom_range(0, 2)) @(negedge clk);
            end
        join

        for (int w = 0; w < 40 && (q8.size() != 0 || q2.size() != 0); w++)
            @(negedge clk);
        chk("dut8 drain", q8.size(), 0);
        chk("dut2 drain", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
